stopwatch_timer_core: RTL



---
 rtl/stopwatch_timer_core.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: BCD MM:SS stopwatch / countdown with expiry flag,
// configurable minute ceiling, toggle pause, per-field adjust and lap hold.
module stopwatch_timer_core #(
   parameter int unsigned MAX_MIN = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_run,
   input  logic       tick_adj,
   input  logic       pause_btn,
   input  logic       lap_btn,
   input  logic [1:0] adjust,
   input  logic       select,
   input  logic       dir,
   output logic [3:0] min1,
   output logic [3:0] min0,
   output logic [3:0] sec1,
   output logic [3:0] sec0,
   output logic       paused,
   output logic       held,
   output logic       expired
);

   typedef enum logic [1:0] {
      PAUSED  = 2'd0,
      RUNNING = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);
   localparam logic [7:0] MAX_MM = {MAX_M1, MAX_M0};

   state_t     state_q;
   logic [7:0] min_q, min_d;   // {tens, ones} BCD
   logic [7:0] sec_q, sec_d;
   logic [7:0] lap_min_q, lap_sec_q;
   logic       held_q, paused_q, expired_q;

   logic [7:0] min_inc, min_dec, sec_inc, sec_dec;
   logic       adj_apply, run_tick, at_low;

   assign adj_apply = tick_adj && (adjust != 2'b00);
   assign run_tick  = tick_run && (adjust == 2'b00) && (state_q == RUNNING);
   // Down-count reaching or already at 00:00 on this tick means expiry.
   assign at_low    = (min_q == 8'h00) && ((sec_q == 8'h00) || (sec_q == 8'h01));

   // Wrapping single-step neighbours of each field, no inter-field carry.
   always_comb begin
      if (min_q == MAX_MM)        min_inc = '0;
      else if (min_q[3:0] == 4'd9) min_inc = {min_q[7:4] + 4'd1, 4'd0};
      else                         min_inc = {min_q[7:4], min_q[3:0] + 4'd1};

      if (min_q == 8'h00)          min_dec = MAX_MM;
      else if (min_q[3:0] == 4'd0) min_dec = {min_q[7:4] - 4'd1, 4'd9};
      else                         min_dec = {min_q[7:4], min_q[3:0] - 4'd1};

      if (sec_q == 8'h59)          sec_inc = '0;
      else if (sec_q[3:0] == 4'd9) sec_inc = {sec_q[7:4] + 4'd1, 4'd0};
      else                         sec_inc = {sec_q[7:4], sec_q[3:0] + 4'd1};

      if (sec_q == 8'h00)          sec_dec = 8'h59;
      else if (sec_q[3:0] == 4'd0) sec_dec = {sec_q[7:4] - 4'd1, 4'd9};
      else                         sec_dec = {sec_q[7:4], sec_q[3:0] - 4'd1};
   end

   // Next count value: an applied adjust wins over a run tick.
   always_comb begin
      min_d = min_q;
      sec_d = sec_q;
      if (adj_apply) begin
         if (select) begin
            case (adjust)
               2'b01:   sec_d = sec_inc;
               2'b10:   sec_d = sec_dec;
               2'b11:   sec_d = '0;
               default: sec_d = sec_q;
            endcase
         end else begin
            case (adjust)
               2'b01:   min_d = min_inc;
               2'b10:   min_d = min_dec;
               2'b11:   min_d = '0;
               default: min_d = min_q;
            endcase
         end
      end else if (run_tick) begin
         if (!dir) begin
            if (sec_q == 8'h59) begin
               sec_d = '0;
               min_d = min_inc;
            end else begin
               sec_d = sec_inc;
            end
         end else if ((min_q != 8'h00) || (sec_q != 8'h00)) begin
            if (sec_q == 8'h00) begin
               sec_d = 8'h59;
               min_d = min_dec;
            end else begin
               sec_d = sec_dec;
            end
         end
      end
   end

   // State, count, lap and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= PAUSED;
         min_q     <= '0;
         sec_q     <= '0;
         lap_min_q <= '0;
         lap_sec_q <= '0;
         held_q    <= 1'b0;
         paused_q  <= 1'b1;
         expired_q <= 1'b0;
      end else begin
         min_q <= min_d;
         sec_q <= sec_d;

         if (lap_btn) begin
            if (!held_q) begin
               lap_min_q <= min_q;
               lap_sec_q <= sec_q;
               held_q    <= 1'b1;
            end else begin
               held_q    <= 1'b0;
            end
         end

         // pause_btn outranks an expiry on the same tick
         case (state_q)
            PAUSED: begin
               if (pause_btn) begin
                  state_q   <= RUNNING;
                  paused_q  <= 1'b0;
                  expired_q <= 1'b0;
               end
            end
            RUNNING: begin
               if (pause_btn) begin
                  state_q   <= PAUSED;
                  paused_q  <= 1'b1;
                  expired_q <= 1'b0;
               end else if (run_tick && dir && at_low) begin
                  state_q   <= EXPIRED;
                  paused_q  <= 1'b0;
                  expired_q <= 1'b1;
               end
            end
            EXPIRED: begin
               if (pause_btn || adj_apply) begin
                  state_q   <= PAUSED;
                  paused_q  <= 1'b1;
                  expired_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= PAUSED;
               paused_q  <= 1'b1;
               expired_q <= 1'b0;
            end
         endcase
      end
   end

   assign min1    = held_q ? lap_min_q[7:4] : min_q[7:4];
   assign min0    = held_q ? lap_min_q[3:0] : min_q[3:0];
   assign sec1    = held_q ? lap_sec_q[7:4] : sec_q[7:4];
   assign sec0    = held_q ? lap_sec_q[3:0] : sec_q[3:0];
   assign held    = held_q;
   assign paused  = paused_q;
   assign expired = expired_q;

endmodule
